// File: rtl/screamrun_pkg.sv
// Shared types and constants for the screamrun video pipeline.
// Colours are packed {blue, green, red}, RGB_W bits per channel.
package screamrun_pkg;

    localparam int RGB_W = 4;
    localparam int PIX_W = 3 * RGB_W;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        FLASH = 2'd1,
        DEAD  = 2'd2
    } boss_state_t;

    localparam logic [PIX_W-1:0] DEFAULT_FLASH_COLOR = 12'hFFF;
    localparam logic [PIX_W-1:0] BLANK_COLOR         = 12'h000;

    function automatic logic [PIX_W-1:0] pack_rgb(
        input logic [RGB_W-1:0] red,
        input logic [RGB_W-1:0] green,
        input logic [RGB_W-1:0] blue
    );
        return {blue, green, red};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Reset-clearable shift register; each bit returns to its own RESET_VALUE bit.
module vga_sync_delay #(
    parameter int               DEPTH       = 2,
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift data_in through DEPTH stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESET_VALUE;
            end
        end else begin
            stage_r[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign data_out = stage_r[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Final pixel stage: priority layer mux, sync alignment and the boss hit/health FSM.
// Syncs lag their raw inputs by LAYER_LAT+1; colour lags the layer inputs by one cycle.
module pixel_compositor
    import screamrun_pkg::*;
#(
    parameter int               LAYER_LAT    = 2,
    parameter int               FLASH_FRAMES = 8,
    parameter int               BOSS_HP      = 5,
    parameter logic [PIX_W-1:0] FLASH_COLOR  = DEFAULT_FLASH_COLOR
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             visible,
    input  logic             hit,
    input  logic [RGB_W-1:0] bg_red,
    input  logic [RGB_W-1:0] bg_green,
    input  logic [RGB_W-1:0] bg_blue,
    input  logic [RGB_W-1:0] player_red,
    input  logic [RGB_W-1:0] player_green,
    input  logic [RGB_W-1:0] player_blue,
    input  logic             player_visible,
    input  logic [RGB_W-1:0] boss_red,
    input  logic [RGB_W-1:0] boss_green,
    input  logic [RGB_W-1:0] boss_blue,
    input  logic             boss_visible,
    output logic [RGB_W-1:0] vga_red,
    output logic [RGB_W-1:0] vga_green,
    output logic [RGB_W-1:0] vga_blue,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [3:0]       boss_hits,
    output logic             boss_defeated
);

    localparam logic [3:0] HP_LIMIT   = 4'(BOSS_HP);
    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_FRAMES);

    logic [2:0]       sync_d_s;
    logic             hs_d_s, vs_d_s, vis_d_s;
    logic             hit_q_r, vsync_q_r;
    logic             hit_edge_s, frame_tick_s;
    boss_state_t      state_r, state_n_s;
    logic [3:0]       hits_r, hits_n_s, hits_inc_s;
    logic [3:0]       flash_cnt_r, flash_cnt_n_s;
    logic             defeated_r;
    logic [PIX_W-1:0] pix_n_s;

    vga_sync_delay #(
        .DEPTH       (LAYER_LAT),
        .WIDTH       (3),
        .RESET_VALUE (3'b110)
    ) u_sync_delay (
        .clock    (clock),
        .reset    (reset),
        .data_in  ({hsync_in, vsync_in, visible}),
        .data_out (sync_d_s)
    );

    assign hs_d_s       = sync_d_s[2];
    assign vs_d_s       = sync_d_s[1];
    assign vis_d_s      = sync_d_s[0];
    assign hit_edge_s   = hit & ~hit_q_r;
    assign frame_tick_s = vsync_q_r & ~vsync_in;
    assign hits_inc_s   = hits_r + 4'd1;

    // Boss FSM next state: a hit edge always wins over a same-cycle frame tick.
    always_comb begin
        state_n_s     = state_r;
        hits_n_s      = hits_r;
        flash_cnt_n_s = flash_cnt_r;
        case (state_r)
            ALIVE, FLASH: begin
                if (hit_edge_s) begin
                    hits_n_s = hits_inc_s;
                    if (hits_inc_s == HP_LIMIT) begin
                        state_n_s     = DEAD;
                        flash_cnt_n_s = 4'd0;
                    end else begin
                        state_n_s     = FLASH;
                        flash_cnt_n_s = FLASH_LOAD;
                    end
                end else if ((state_r == FLASH) && frame_tick_s) begin
                    flash_cnt_n_s = flash_cnt_r - 4'd1;
                    if (flash_cnt_r == 4'd1) begin
                        state_n_s = ALIVE;
                    end else begin
                        state_n_s = FLASH;
                    end
                end else begin
                    state_n_s = state_r;
                end
            end
            DEAD: begin
                state_n_s = DEAD;
            end
            default: begin
                state_n_s     = ALIVE;
                hits_n_s      = 4'd0;
                flash_cnt_n_s = 4'd0;
            end
        endcase
    end

    // Layer priority mux on the aligned visible flag; flash blinks in 2-frame runs.
    always_comb begin
        pix_n_s = BLANK_COLOR;
        if (!vis_d_s) begin
            pix_n_s = BLANK_COLOR;
        end else if (boss_visible && (state_r != DEAD)) begin
            if ((state_r == FLASH) && flash_cnt_r[1]) begin
                pix_n_s = FLASH_COLOR;
            end else begin
                pix_n_s = pack_rgb(boss_red, boss_green, boss_blue);
            end
        end else if (player_visible) begin
            pix_n_s = pack_rgb(player_red, player_green, player_blue);
        end else begin
            pix_n_s = pack_rgb(bg_red, bg_green, bg_blue);
        end
    end

    // Boss state, edge detectors and defeat flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ALIVE;
            hits_r      <= 4'd0;
            flash_cnt_r <= 4'd0;
            hit_q_r     <= 1'b0;
            vsync_q_r   <= 1'b1;
            defeated_r  <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            hits_r      <= hits_n_s;
            flash_cnt_r <= flash_cnt_n_s;
            hit_q_r     <= hit;
            vsync_q_r   <= vsync_in;
            defeated_r  <= (state_n_s == DEAD);
        end
    end

    // Output register for colour and aligned syncs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_red   <= 4'd0;
            vga_green <= 4'd0;
            vga_blue  <= 4'd0;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
        end else begin
            vga_red   <= pix_n_s[RGB_W-1:0];
            vga_green <= pix_n_s[2*RGB_W-1:RGB_W];
            vga_blue  <= pix_n_s[3*RGB_W-1:2*RGB_W];
            vga_hs    <= hs_d_s;
            vga_vs    <= vs_d_s;
        end
    end

    assign boss_hits     = hits_r;
    assign boss_defeated = defeated_r;

endmodule
